adc_sampler: RTL and testbench
==============================

# adc_sampler

Front-end sample source for the grid-voltage filter chain. It runs on the 5.4 MHz CLKDIV clock and derives the 3 kHz sample tick from it. On each tick it reads one conversion from an external serial (SPI-style, read-only) ADC and converts the offset-binary code to two's complement. It then presents the sample together with a level enable pulse that downstream moving-average filters use as their sample clock.

## Interface
Parameters:
- NB_SAMPLE, 8, ADC data bits; output width
- DIV_SAMPLE, 1800, clk cycles per sample period (5.4 MHz / 3 kHz)
- NB_DIV, 11, width of the sample-period counter; must satisfy 2^NB_DIV >= DIV_SAMPLE
- SCLK_HALF, 2, clk cycles per SCLK half-period (SCLK = 1.35 MHz)
- NB_LEAD, 2, leading SCLK periods discarded before the data MSB
- PULSE_LEN, 4, o_enable high time in clk cycles

Ports:
- clk  in  1  5.4 MHz system clock from CLKDIV
- rst  in  1  asynchronous, active-high reset
- i_run  in  1  conversions are allowed while high
- i_adc_miso  in  1  ADC serial data, MSB first
- o_adc_cs_n  out  1  ADC chip select, active low
- o_adc_sclk  out  1  ADC serial clock, idle low
- o_xn  out  NB_SAMPLE  signed sample, S(8,7)
- o_enable  out  1  sample-valid level pulse (3 kHz)
- o_busy  out  1  high while a conversion is in progress

## Operation
- Sample counter:
  - Counts 0..DIV_SAMPLE-1 free-running from reset and wraps to 0.
  - Tick = the cycle in which the count equals DIV_SAMPLE-1.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE:
  - cs_n=1, sclk=0.
  - On a tick with i_run=1, go to SETUP.
  - Ticks are ignored while i_run=0; the counter keeps running.
- SETUP:
  - cs_n=0 for SCLK_HALF cycles, then go to SHIFT.
- SHIFT:
  - Runs NB_LEAD+NB_SAMPLE SCLK periods, each SCLK_HALF cycles low then SCLK_HALF cycles high.
  - i_adc_miso is sampled in the clk cycle in which sclk rises.
  - The first NB_LEAD bits are discarded; the rest are shifted in MSB first.
  - After the final high half, go to DONE.
- DONE:
  - cs_n=1, sclk=0.
  - o_xn <= {~shift[NB_SAMPLE-1], shift[NB_SAMPLE-2:0]} (offset binary to two's complement).
  - o_enable is high for PULSE_LEN cycles, then the FSM returns to IDLE.
- o_xn holds its value until the next DONE. It is stable for the whole high time of o_enable and for the full period after it.
- o_busy=1 in SETUP, SHIFT and DONE.
- i_run falling mid-conversion: the current conversion completes normally, including the o_enable pulse. No further conversions start.
- A tick arriving while busy is ignored. This cannot occur under the legal constraint 1+SCLK_HALF*(1+2*(NB_LEAD+NB_SAMPLE))+PULSE_LEN < DIV_SAMPLE.

## Timing
- Reset values (asynchronous, immediate, including mid-conversion):
  - o_adc_cs_n=1, o_adc_sclk=0, o_xn=0, o_enable=0, o_busy=0.
  - Counter=0, FSM=IDLE, shift register=0.
- All outputs are registered; no combinational paths from inputs to outputs.
- cs_n falls 1 cycle after the tick cycle.
- Each sclk rising edge occurs SCLK_HALF*(1+2k)+SCLK_HALF cycles after cs_n falls, for bit k.
- o_enable rises, and o_xn updates in the same cycle, 1+SCLK_HALF*(1+2*(NB_LEAD+NB_SAMPLE)) cycles after the tick. Default: 43 cycles.
- o_enable rising edges are exactly DIV_SAMPLE cycles apart while i_run stays high.
- o_enable is low for at least one cycle between pulses, as required by downstream edge detection.

## Structure
- Shared include/package adc_pkg:
  - FSM state encodings (2-bit localparams).
  - Default values of DIV_SAMPLE, SCLK_HALF, NB_LEAD and PULSE_LEN.
  - Clock-rate constants shared with the filter blocks.
- One sub-module, spi_rx_shift:
  - Contains the SCLK half-period counter, the bit counter and the shift register.
  - start/done handshake with the FSM.
- adc_sampler contains the sample counter, the FSM, the output format conversion and the enable pulse counter.

## Test plan
- MISO model returns 0x80 after 2 lead bits: o_xn=0x00, and o_enable rises 43 cycles after the tick.
- Codes 0xFF and 0x00: o_xn=0x7F, then 0x80 (-128). o_enable high for exactly 4 cycles each time.
- Run 5 periods with i_run=1: o_enable rising edges are exactly 1800 cycles apart; 10 sclk rising edges per conversion; cs_n low for 42 cycles.
- Drop i_run during SHIFT: that conversion completes with the correct o_xn and one o_enable pulse. No cs_n activity afterwards until i_run returns, and restart occurs at the next tick.
- Assert rst during SHIFT: cs_n=1, sclk=0, o_xn=0, o_busy=0 immediately. After release, the first cs_n fall occurs 1800 cycles later.
- Alternating codes 0x00/0xFF each period: o_xn never changes while o_enable=1 or between pulses.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants for the grid-voltage front end: FSM encodings, sampler
// defaults and clock-rate figures used by the downstream filter blocks.
package adc_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SETUP_ENC = 2'd1;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SETUP = ST_SETUP_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    localparam int DIV_SAMPLE_DEF = 1800;
    localparam int SCLK_HALF_DEF  = 2;
    localparam int NB_LEAD_DEF    = 2;
    localparam int PULSE_LEN_DEF  = 4;

    localparam int CLK_HZ    = 5_400_000;
    localparam int FS_HZ     = 3_000;
    localparam int SCLK_HZ   = CLK_HZ / (2 * SCLK_HALF_DEF);

    // Cycles from sample tick to the o_enable rising edge.
    function automatic int conv_latency(input int sclk_half, input int nb_lead,
                                        input int nb_sample);
        return 1 + sclk_half * (1 + 2 * (nb_lead + nb_sample));
    endfunction

endpackage

// File: rtl/spi_rx_shift.sv
// Read-only SPI receiver: generates SCLK, samples MISO on each rising SCLK
// cycle, drops the leading bits and shifts the data MSB first.
module spi_rx_shift #(
    parameter int NB_SAMPLE = 8,
    parameter int SCLK_HALF = 2,
    parameter int NB_LEAD   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 done,
    output logic [NB_SAMPLE-1:0] data
);

    localparam int NB_BITS = NB_LEAD + NB_SAMPLE;
    localparam int NB_BCNT = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;
    localparam int NB_HCNT = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    localparam logic [NB_HCNT-1:0] HLAST  = NB_HCNT'(SCLK_HALF - 1);
    localparam logic [NB_BCNT-1:0] BLAST  = NB_BCNT'(NB_BITS - 1);
    localparam logic [NB_BCNT-1:0] BFIRST = NB_BCNT'(NB_LEAD);

    logic                 active;
    logic [NB_HCNT-1:0]   hcnt;
    logic [NB_BCNT-1:0]   bcnt;
    logic [NB_SAMPLE-1:0] shift_q;
    logic                 half_end;
    logic                 sample;

    assign half_end = active && (hcnt == HLAST);
    // First cycle of the high half is the one in which SCLK has just risen.
    assign sample   = active && sclk && (hcnt == '0) && (bcnt >= BFIRST);
    assign done     = half_end && sclk && (bcnt == BLAST);
    assign data     = shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            hcnt    <= '0;
            bcnt    <= '0;
            sclk    <= 1'b0;
            shift_q <= '0;
        end else if (start) begin
            active <= 1'b1;
            hcnt   <= '0;
            bcnt   <= '0;
            sclk   <= 1'b0;
        end else if (active) begin
            if (sample) begin
                shift_q <= {shift_q[NB_SAMPLE-2:0], miso};
            end
            if (half_end) begin
                hcnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                    if (bcnt == BLAST) begin
                        active <= 1'b0;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// 3 kHz sample source: divides the system clock into a sample tick, runs one
// ADC conversion per tick and presents a two's-complement sample with a level enable.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int NB_SAMPLE  = 8,
    parameter int DIV_SAMPLE = DIV_SAMPLE_DEF,
    parameter int NB_DIV     = 11,
    parameter int SCLK_HALF  = SCLK_HALF_DEF,
    parameter int NB_LEAD    = NB_LEAD_DEF,
    parameter int PULSE_LEN  = PULSE_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic                 i_adc_miso,
    output logic                 o_adc_cs_n,
    output logic                 o_adc_sclk,
    output logic [NB_SAMPLE-1:0] o_xn,
    output logic                 o_enable,
    output logic                 o_busy
);

    localparam int PCNT_MAX = (SCLK_HALF > PULSE_LEN) ? SCLK_HALF : PULSE_LEN;
    localparam int NB_PCNT  = (PCNT_MAX > 1) ? $clog2(PCNT_MAX) : 1;

    localparam logic [NB_DIV-1:0]  DIV_LAST   = NB_DIV'(DIV_SAMPLE - 1);
    localparam logic [NB_PCNT-1:0] SETUP_LAST = NB_PCNT'(SCLK_HALF - 1);
    localparam logic [NB_PCNT-1:0] PULSE_LAST = NB_PCNT'(PULSE_LEN - 1);

    logic [NB_DIV-1:0]    div_cnt;
    logic                 tick;
    state_t               state;
    state_t               state_nxt;
    logic [NB_PCNT-1:0]   pcnt;
    logic [NB_PCNT-1:0]   pcnt_nxt;
    logic                 spi_start;
    logic                 spi_done;
    logic                 load_xn;
    logic [NB_SAMPLE-1:0] spi_data;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    spi_rx_shift #(
        .NB_SAMPLE (NB_SAMPLE),
        .SCLK_HALF (SCLK_HALF),
        .NB_LEAD   (NB_LEAD)
    ) u_spi (
        .clk   (clk),
        .rst   (rst),
        .start (spi_start),
        .miso  (i_adc_miso),
        .sclk  (o_adc_sclk),
        .done  (spi_done),
        .data  (spi_data)
    );

    // pcnt is shared: SETUP hold time and enable pulse width never overlap.
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        spi_start = 1'b0;
        load_xn   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick && i_run) begin
                    state_nxt = ST_SETUP;
                    pcnt_nxt  = '0;
                end
            end
            ST_SETUP: begin
                if (pcnt == SETUP_LAST) begin
                    state_nxt = ST_SHIFT;
                    spi_start = 1'b1;
                    pcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (spi_done) begin
                    state_nxt = ST_DONE;
                    load_xn   = 1'b1;
                    pcnt_nxt  = '0;
                end
            end
            ST_DONE: begin
                if (pcnt == PULSE_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    pcnt_nxt = pcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pcnt_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pcnt       <= '0;
            o_adc_cs_n <= 1'b1;
            o_busy     <= 1'b0;
            o_enable   <= 1'b0;
            o_xn       <= '0;
        end else begin
            state      <= state_nxt;
            pcnt       <= pcnt_nxt;
            o_adc_cs_n <= !((state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT));
            o_busy     <= (state_nxt != ST_IDLE);
            o_enable   <= (state_nxt == ST_DONE);
            if (load_xn) begin
                o_xn <= {~spi_data[NB_SAMPLE-1], spi_data[NB_SAMPLE-2:0]};
            end
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: table of ADC codes with expected samples,
// plus hand sequences for i_run drop and reset during a conversion.
module tb_adc_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_run = 1'b0;
    logic       i_adc_miso = 1'b0;
    logic       o_adc_cs_n;
    logic       o_adc_sclk;
    logic [7:0] o_xn;
    logic       o_enable;
    logic       o_busy;

    always #5 clk = ~clk;

    adc_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .i_run      (i_run),
        .i_adc_miso (i_adc_miso),
        .o_adc_cs_n (o_adc_cs_n),
        .o_adc_sclk (o_adc_sclk),
        .o_xn       (o_xn),
        .o_enable   (o_enable),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic [1:0] lead;
        logic [7:0] code;
        logic [7:0] exp_xn;
    } vec_t;

    vec_t tbl [8];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    // ADC model and activity monitor, both evaluated on the falling clock edge.
    logic [9:0] frame = 10'd0;
    logic       p_cs = 1'b1, p_sclk = 1'b0, p_en = 1'b0;
    logic [7:0] p_xn = 8'd0;
    int n_cs_fall = 0, n_en_rise = 0, n_en_fall = 0, n_bad_xn = 0;
    int cs_fall_cyc = 0, cs_low_len = 0, sclk_rises = 0, sclk_falls = 0;
    int en_rise_cyc = 0, prev_en_rise = 0, en_width = 0;

    always @(negedge clk) begin
        if (p_cs && !o_adc_cs_n) begin
            cs_fall_cyc = cyc;
            sclk_rises  = 0;
            sclk_falls  = 0;
            n_cs_fall   = n_cs_fall + 1;
        end
        if (!p_cs && o_adc_cs_n) cs_low_len = cyc - cs_fall_cyc;
        if (!p_sclk && o_adc_sclk) sclk_rises = sclk_rises + 1;
        if (p_sclk && !o_adc_sclk && !o_adc_cs_n) sclk_falls = sclk_falls + 1;
        if (o_xn != p_xn && !(!p_en && o_enable) && !rst) n_bad_xn = n_bad_xn + 1;
        if (!p_en && o_enable) begin
            prev_en_rise = en_rise_cyc;
            en_rise_cyc  = cyc;
            n_en_rise    = n_en_rise + 1;
        end
        if (p_en && !o_enable) begin
            en_width  = cyc - en_rise_cyc;
            n_en_fall = n_en_fall + 1;
        end
        i_adc_miso = (sclk_falls < 10) ? frame[9 - sclk_falls] : 1'b0;
        p_cs   = o_adc_cs_n;
        p_sclk = o_adc_sclk;
        p_en   = o_enable;
        p_xn   = o_xn;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cs_fall(input int budget);
        int n0;
        n0 = n_cs_fall;
        for (int i = 0; i < budget && n_cs_fall == n0; i++) @(negedge clk);
        chk("cs_fall_seen", (n_cs_fall != n0) ? 1 : 0, 1);
    endtask

    task automatic wait_en_fall(input int budget);
        int n0;
        n0 = n_en_fall;
        for (int i = 0; i < budget && n_en_fall == n0; i++) @(negedge clk);
        chk("enable_pulse_seen", (n_en_fall != n0) ? 1 : 0, 1);
    endtask

    initial begin
        int rel;
        int f0;
        int ne;
        int nc;

        tbl[0] = '{2'b10, 8'h80, 8'h00};
        tbl[1] = '{2'b01, 8'hFF, 8'h7F};
        tbl[2] = '{2'b11, 8'h00, 8'h80};
        tbl[3] = '{2'b00, 8'hFF, 8'h7F};
        tbl[4] = '{2'b11, 8'h00, 8'h80};
        tbl[5] = '{2'b10, 8'h01, 8'h81};
        tbl[6] = '{2'b01, 8'h7F, 8'hFF};
        tbl[7] = '{2'b11, 8'hA5, 8'h25};

        repeat (3) @(negedge clk);
        chk("reset_cs_n", int'(o_adc_cs_n), 1);
        chk("reset_sclk", int'(o_adc_sclk), 0);
        chk("reset_xn", int'(o_xn), 0);
        chk("reset_enable", int'(o_enable), 0);
        chk("reset_busy", int'(o_busy), 0);

        frame = {tbl[0].lead, tbl[0].code};
        rst   = 1'b0;
        i_run = 1'b1;
        rel   = cyc;

        for (int v = 0; v < 8; v++) begin
            frame = {tbl[v].lead, tbl[v].code};
            wait_cs_fall(2000);
            if (v == 0) chk("first_cs_fall_after_reset", cs_fall_cyc - rel, 1800);
            wait_en_fall(200);
            chk("xn", int'(o_xn), int'(tbl[v].exp_xn));
            chk("enable_latency_from_cs", en_rise_cyc - cs_fall_cyc, 42);
            chk("enable_width", en_width, 4);
            chk("sclk_rises", sclk_rises, 10);
            chk("cs_low_cycles", cs_low_len, 42);
            if (v > 0) chk("enable_period", en_rise_cyc - prev_en_rise, 1800);
        end
        chk("xn_stable_outside_update", n_bad_xn, 0);

        // Drop i_run in the middle of a conversion.
        frame = {2'b10, 8'h3C};
        wait_cs_fall(2000);
        f0 = cs_fall_cyc;
        ne = n_en_rise;
        repeat (10) @(negedge clk);
        chk("busy_in_shift", int'(o_busy), 1);
        i_run = 1'b0;
        wait_en_fall(200);
        chk("xn_after_run_drop", int'(o_xn), 8'hBC);
        chk("enable_pulses_after_run_drop", n_en_rise - ne, 1);
        nc = n_cs_fall;
        while (cyc < f0 + 4000) @(negedge clk);
        chk("no_cs_while_stopped", n_cs_fall - nc, 0);
        i_run = 1'b1;
        wait_cs_fall(2000);
        chk("restart_at_next_tick", cs_fall_cyc - f0, 5400);

        // Reset while SCLK is high mid-conversion.
        for (int i = 0; i < 100 && !o_adc_sclk; i++) @(negedge clk);
        chk("sclk_high_before_reset", int'(o_adc_sclk), 1);
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", int'(o_adc_cs_n), 1);
        chk("midrst_sclk", int'(o_adc_sclk), 0);
        chk("midrst_xn", int'(o_xn), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_enable", int'(o_enable), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        wait_cs_fall(2000);
        chk("cs_fall_after_midrst", cs_fall_cyc - rel, 1800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
